// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
//
// Time-multiplexed driver for a common-anode 7-segment display. It takes the
// BCD outputs of the decade counter chain (digit 0 = least significant) and
// scans one digit at a time. Each digit is driven for REFRESH_DIV cycles and
// is followed by a single blank cycle, which stops the previous digit's
// segments from ghosting onto the next anode.
//
// Newly loaded digit values are first held in a pending shadow register. They
// are copied to the displayed (active) copy only at a frame boundary, so a
// single frame never mixes old and new digit values.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros. Digit
// 0 is never blanked, and any invalid code (A-F) ends the run of leading zeros.
//
// Parameters
//   NDIG         number of digits scanned (1..8)
//   REFRESH_DIV  cycles each digit is driven per slot (>= 2)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous reset, active-low
//   enable      in   1 = scan; 0 = hold scan position and blank all outputs
//   load        in   capture strobe for bcd_in / dp_in
//   bcd_in      in   4*NDIG bits, digit i on bits [4i+3:4i]
//   dp_in       in   NDIG bits, decimal point per digit, 1 = lit
//   seg         out  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low
//   an          out  digit anode enables, active-low, at most one low
//   frame_done  out  one-cycle pulse during the blank cycle at a frame boundary
// -----------------------------------------------------------------------------
module bcd_display_scan #(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic [NDIG-1:0]   dp_in,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  typedef enum logic {
    S_GAP   = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic              frame_q, frame_d;
  logic [4*NDIG-1:0] pend_bcd_q, pend_bcd_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
  logic              pend_valid_q, pend_valid_d;
  logic [4*NDIG-1:0] act_bcd_q, act_bcd_d;
  logic [NDIG-1:0]   act_dp_q, act_dp_d;
  logic              boundary;

  logic [3:0]        digits [NDIG];
  logic [NDIG-1:0]   blank_mask;
  logic [3:0]        cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // dash marks an invalid code
    endcase
    return s;
  endfunction

  // Split the active word into individual digits.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign digits[gi] = act_bcd_q[4*gi +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // zrun[i] is 1 when digit i and every digit above it are zero. A nonzero
  // digit, including an invalid code, breaks the chain.
  logic [NDIG:0] zrun;
  assign zrun[NDIG] = 1'b1;
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_lzb
      assign zrun[gi] = zrun[gi+1] & (digits[gi] == 4'd0);
      if (gi == 0) begin : g_d0
        assign blank_mask[gi] = 1'b0;
      end else begin : g_dn
        assign blank_mask[gi] = zrun[gi];
      end
    end
  endgenerate
`else
  assign blank_mask = '0;
`endif

  assign cur_digit = digits[idx_q];

  // Next-state logic for the scan sequencer and the digit data registers.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rcnt_d       = rcnt_q;
    frame_d      = frame_q;
    boundary     = 1'b0;
    pend_bcd_d   = pend_bcd_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_bcd_d    = act_bcd_q;
    act_dp_d     = act_dp_q;

    if (enable) begin
      case (state_q)
        S_GAP: begin
          state_d = S_DRIVE;
          rcnt_d  = '0;
          frame_d = 1'b0;
        end
        S_DRIVE: begin
          if (rcnt_q == RCNT_LAST) begin
            state_d = S_GAP;
            rcnt_d  = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              frame_d  = 1'b1;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: state_d = S_GAP;
      endcase
    end

    // A load that lands exactly on the boundary goes straight to the display,
    // so it is not held back for a whole extra frame.
    if (load) begin
      pend_bcd_d = bcd_in;
      pend_dp_d  = dp_in;
      if (boundary) begin
        act_bcd_d    = bcd_in;
        act_dp_d     = dp_in;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = 1'b1;
      end
    end else if (boundary && pend_valid_q) begin
      act_bcd_d    = pend_bcd_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_GAP;
      idx_q        <= '0;
      rcnt_q       <= '0;
      frame_q      <= 1'b0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_bcd_q    <= '0;
      act_dp_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rcnt_q       <= rcnt_d;
      frame_q      <= frame_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      act_bcd_q    <= act_bcd_d;
      act_dp_q     <= act_dp_d;
    end
  end

  // Outputs come straight from the current registers, with no extra latency.
  always_comb begin
    seg        = 7'h7F;
    dp         = 1'b1;
    an         = '1;
    frame_done = 1'b0;
    if (enable) begin
      frame_done = (state_q == S_GAP) && frame_q;
      if (state_q == S_DRIVE) begin
        an  = ~(NDIG'(1) << idx_q);
        seg = blank_mask[idx_q] ? 7'h7F : decode(cur_digit);
        dp  = ~act_dp_q[idx_q];
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
module tb_bcd_display_scan;

  localparam int NDIG  = 4;
  localparam int RD    = 4;
  localparam int SLOT  = RD + 1;
  localparam int FRAME = NDIG * SLOT;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  bcd_display_scan #(.NDIG(NDIG), .REFRESH_DIV(RD)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errs    = 0;

  // Reference model: t counts enabled clock edges since reset was released.
  // The display position follows from t alone: t mod FRAME == 0 is the blank
  // cycle, and each digit slot after it is RD driven cycles plus one blank.
  int          t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pv;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 4'd9) return 7'b0111111;
    return tab[v];
  endfunction

  task automatic model_reset();
    t = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pv = 0;
  endtask

  task automatic check(input string tag);
    int p, slot;
    bit drive, fd;
    logic [3:0] nib, e_an;
    logic [6:0] e_seg;
    logic e_dp;
    p = t % FRAME; slot = 0; drive = 0; fd = 0;
    if (p == 0) fd = (t > 0);
    else begin
      slot  = (p - 1) / SLOT;
      drive = ((p - 1) % SLOT) < RD;
    end
    if (!enable || !reset) begin drive = 0; fd = 0; end
    nib   = 4'(m_act >> (4 * slot));
    e_an  = drive ? ~(4'b0001 << slot) : 4'hF;
    e_seg = drive ? seg_of(nib) : 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    if (drive && slot > 0 && (m_act >> (4 * slot)) == 16'h0) e_seg = 7'h7F;
`endif
    e_dp = drive ? ~m_act_dp[slot] : 1'b1;
    vectors += 4;
    assert (an === e_an) else begin
      errs++; $error("FAIL %s an t=%0d observed=%b expected=%b", tag, t, an, e_an);
    end
    assert (seg === e_seg) else begin
      errs++; $error("FAIL %s seg t=%0d observed=%b expected=%b", tag, t, seg, e_seg);
    end
    assert (dp === e_dp) else begin
      errs++; $error("FAIL %s dp t=%0d observed=%b expected=%b", tag, t, dp, e_dp);
    end
    assert (frame_done === fd) else begin
      errs++; $error("FAIL %s frame_done t=%0d observed=%b expected=%b", tag, t, frame_done, fd);
    end
    $display("t=%0d en=%b an=%b seg=%b dp=%b fd=%b [%s]", t, enable, an, seg, dp, frame_done, tag);
  endtask

  // One clock: drive inputs, advance the model across the edge, then check
  // the outputs on the falling edge.
  task automatic tick(input logic en, input logic ld, input logic [15:0] b,
                      input logic [3:0] d, input string tag);
    bit bnd;
    enable = en; load = ld; bcd_in = b; dp_in = d;
    @(posedge clock);
    bnd = en && ((t % FRAME) == FRAME - 1);
    if (ld) begin
      m_pend = b; m_pend_dp = d;
      if (bnd) begin m_act = b; m_act_dp = d; m_pv = 0; end
      else m_pv = 1;
    end else if (bnd && m_pv) begin
      m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 0;
    end
    if (en) t++;
    @(negedge clock);
    load = 1'b0;
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, bcd_in, dp_in, tag);
  endtask

  // Advance (bounded) until the next edge starts from phase ph.
  task automatic run_to(input int ph, input string tag);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != ph; i++)
      tick(1'b1, 1'b0, bcd_in, dp_in, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    #1 reset = 1'b0;
    #1 model_reset();
    check({tag, "_async"});
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    check({tag, "_held"});
    reset = 1'b1;
    #1 check({tag, "_release"});
  endtask

  initial begin
    model_reset();
    enable = 1'b1;
    #12;
    reset = 1'b1;
    @(negedge clock);
    do_reset("reset");

    // Scan: load before the first boundary, shown from the next frame.
    tick(1'b1, 1'b1, 16'h1234, 4'b0000, "scan_load");
    idle(2 * FRAME, "scan");

    // Decode incl. invalid code and decimal point.
    tick(1'b1, 1'b1, 16'h9A07, 4'b0100, "decode_load");
    idle(2 * FRAME, "decode");

    // Tear-free: load while digit 1 is being driven.
    run_to(7, "tear_seek");
    tick(1'b1, 1'b1, 16'h5555, 4'b1010, "tear_load");
    idle(FRAME + 5, "tear");
    // Load on the boundary edge itself.
    run_to(FRAME - 1, "bnd_seek");
    tick(1'b1, 1'b1, 16'h8642, 4'b0001, "bnd_load");
    idle(FRAME + 2, "bnd");

    // Enable low for 7 cycles mid-slot, with a load captured meanwhile.
    run_to(12, "pause_seek");
    for (int i = 0; i < 7; i++)
      tick(1'b0, (i == 3), 16'h3141, 4'b0011, "pause");
    idle(2 * FRAME, "resume");

    // Reset mid-slot discards pending data.
    run_to(3, "rst_seek");
    tick(1'b1, 1'b1, 16'h7777, 4'b1111, "rst_load");
    idle(1, "rst_pre");
    do_reset("reset_mid");
    idle(2 * FRAME + 2, "rst_post");

    // Leading-zero cases.
    tick(1'b1, 1'b1, 16'h0040, 4'b0000, "lz40_load");
    idle(2 * FRAME, "lz40");
    tick(1'b1, 1'b1, 16'h0000, 4'b0000, "lz0_load");
    idle(2 * FRAME, "lz0");
    tick(1'b1, 1'b1, 16'h0A01, 4'b0000, "lzA_load");
    idle(2 * FRAME, "lzA");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic en, ld;
      logic [15:0] b;
      logic [3:0] d;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 7) == 0);
      b  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = b & 16'h00FF;
      d  = 4'($urandom);
      tick(en, ld, b, d, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
